cell_window_shifter: RTL
========================

// Module: cell_window_shifter
// PURPOSE
// Parametrised successor to the fixed 20-in/22-out row shift buffer. Accepts CHUNK_W-bit row chunks over a
// valid/ready handshake and builds an OUT_W = CHUNK_W+HALO_W bit neighbourhood window for the automaton update logic.
// Per-chunk mode: whole-chunk step (one window per chunk) or bit step (every chunk bit shifted in MSB-first, one window per bit).
// Sits between the row memory reader and the rule evaluation pipeline; backpressure from the rule side stalls shifting.
// PARAMETERS
// CHUNK_W  20  bits per input chunk (>=2)
// HALO_W   2   history bits kept from the previous chunk (>=1); localparam OUT_W = CHUNK_W+HALO_W, FILL_W = $clog2(OUT_W+1)
// PORTS
// clk         in   1        clock, all state on rising edge
// clear_n     in   1        asynchronous active-low reset
// flush       in   1        synchronous clear of window/hold/fill (row boundary)
// step_bit    in   1        mode latched with each accepted chunk: 1 = bit step, 0 = chunk step
// in_valid    in   1        din valid
// in_ready    out  1        chunk accepted when in_valid & in_ready
// din         in   CHUNK_W  row chunk, MSB is leftmost cell
// out_valid   out  1        dout holds a fresh complete window
// out_ready   in   1        consumer takes window when out_valid & out_ready
// dout        out  OUT_W    window, dout[OUT_W-1] oldest bit
// fill_level  out  FILL_W   valid bits in window, saturates at OUT_W
// BEHAVIOUR
// - Reset (clear_n low, async): window=0, hold=0, hold_cnt=0, hold_mode=0, fill_level=0, out_valid=0; in_ready=1 after release.
// - Hold stage: hold[CHUNK_W-1:0], hold_cnt (bits remaining), hold_mode. Accept fire loads hold<=din, hold_cnt<=CHUNK_W, hold_mode<=step_bit.
// - can_shift = hold_cnt!=0 & (!out_valid | out_ready) & (hold_mode | hold_cnt==CHUNK_W).
// - Chunk step: window <= {window[HALO_W-1:0], hold}; hold_cnt<=0; fill += CHUNK_W (saturate OUT_W).
// - Bit step: window <= {window[OUT_W-2:0], hold[CHUNK_W-1]}; hold <<= 1; hold_cnt -= 1; fill += 1 (saturate).
// - in_ready = (hold_cnt==0) | (can_shift & (hold_mode ? hold_cnt==1 : 1)); combinational on out_ready; back-to-back chunks give full throughput.
// - A chunk accepted in the same cycle as the shift consuming the last held bits loads hold; no bubble, no loss.
// - out_valid: set on a shift whose resulting fill==OUT_W; cleared on out fire with no shift that cycle; stays 1 if shift and out fire coincide.
// - dout = window register directly (no extra latency); window first usable one cycle after the shift.
// - Latency: chunk accepted cycle N -> shifted cycle N+1 -> out_valid visible from N+2 (if filled, consumer ready).
// - out_valid=1 & out_ready=0: window, hold, fill frozen; in_ready low once hold occupied.
// - flush: window=0, hold_cnt=0, fill=0 (or preload value, see CONFIGURATION), out_valid=0 next cycle; priority over accept and shift;
//   in_valid during flush is NOT accepted (in_ready forced 0 while flush=1).
// - step_bit changes never affect a chunk already in hold; mixing modes across chunks is legal.
// - Async reset mid-drain discards hold and window; no partial window is ever presented.
// CONFIGURATION
// CELL_WINDOW_PRELOAD_EN defined: reset and flush set fill_level=OUT_W (window zero = dead-cell boundary);
//   first shift after reset/flush raises out_valid. Chunk mode: window per chunk from the first; bit mode: window from first bit.
// CELL_WINDOW_PRELOAD_EN undefined: fill starts at 0; out_valid only after OUT_W bits shifted in since reset/flush.
// TESTING (defaults CHUNK_W=20, HALO_W=2, macro undefined unless stated)
// 1 clear_n=0 mid-stream -> dout=0, out_valid=0, fill_level=0 immediately; in_ready=1 after release.
// 2 chunk mode, out_ready=1: 20'hABCDE then 20'h12345 -> no window after first (fill=20); then dout=22'h212345, out_valid=1 one cycle.
// 3 bit mode, two chunks 20'hFFFFF, 20'h00000 -> out_valid first after 22nd bit shift with dout=22'h3FFFFC; then one window/cycle for 18 more cycles.
// 4 out_ready=0 while out_valid=1 for 10 cycles -> dout, fill_level stable, in_ready=0; release -> subsequent windows match reference model, no bit lost.
// 5 flush asserted with hold_cnt=7 (bit mode) and in_valid=1 -> next cycle fill_level=0, out_valid=0, that chunk not accepted.
// 6 macro defined: reset, chunk mode 20'hABCDE -> out_valid=1 with dout=22'h0ABCDE two cycles after accept.

Source files
------------

// File: rtl/cell_window_shifter.sv
// cell_window_shifter
//   Builds an OUT_W = CHUNK_W + HALO_W bit neighbourhood window from row
//   chunks for the automaton rule pipeline. Each accepted chunk is either
//   shifted in whole (chunk step, one window per chunk) or one bit at a time
//   MSB-first (bit step, one window per bit). The mode is latched with the
//   chunk. Backpressure from out_ready stalls all shifting.
//
//   Optional build macro: CELL_WINDOW_PRELOAD_EN
//     defined   - reset/flush preload fill_level to OUT_W, so the all-zero
//                 window acts as a dead-cell boundary and the first shift
//                 already produces a window.
//     undefined - fill_level starts at 0; a window is presented only once
//                 OUT_W bits have been shifted in since reset/flush.
//
// Ports
//   clk        in   clock, all state on rising edge
//   clear_n    in   asynchronous active-low reset
//   flush      in   synchronous clear of window/hold/fill (row boundary)
//   step_bit   in   mode for the chunk being accepted: 1 bit step, 0 chunk step
//   in_valid   in   din valid
//   in_ready   out  chunk accepted when in_valid & in_ready
//   din        in   CHUNK_W row chunk, MSB is leftmost cell
//   out_valid  out  dout holds a fresh complete window
//   out_ready  in   consumer takes window when out_valid & out_ready
//   dout       out  OUT_W window, dout[OUT_W-1] oldest bit
//   fill_level out  valid bits in window, saturates at OUT_W
module cell_window_shifter #(
    parameter int CHUNK_W = 20,
    parameter int HALO_W  = 2,
    localparam int OUT_W  = CHUNK_W + HALO_W,
    localparam int FILL_W = $clog2(OUT_W + 1)
) (
    input  logic               clk,
    input  logic               clear_n,
    input  logic               flush,
    input  logic               step_bit,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CHUNK_W-1:0] din,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   dout,
    output logic [FILL_W-1:0]  fill_level
);

    localparam int CNT_W = $clog2(CHUNK_W + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CHUNK_W);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(OUT_W);
`ifdef CELL_WINDOW_PRELOAD_EN
    localparam logic [FILL_W-1:0] FILL_INIT = FILL_MAX;
`else
    localparam logic [FILL_W-1:0] FILL_INIT = '0;
`endif

    logic [OUT_W-1:0]   window;
    logic [CHUNK_W-1:0] hold;
    logic [CNT_W-1:0]   hold_cnt;
    logic               hold_mode;

    logic               can_shift;
    logic               accept;
    logic               out_fire;
    logic [FILL_W:0]    fill_sum;
    logic [FILL_W-1:0]  fill_next;

    assign dout = window;

    always_comb begin
        can_shift = (hold_cnt != '0) && (!out_valid || out_ready)
                    && (hold_mode || (hold_cnt == CNT_FULL));
        // Ready when hold is empty, or when this cycle's shift drains the
        // last held bits, so back-to-back chunks see no bubble.
        in_ready  = !flush && ((hold_cnt == '0)
                    || (can_shift && (!hold_mode || (hold_cnt == CNT_ONE))));
        accept    = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        // One extra bit so the pre-saturation sum cannot wrap.
        fill_sum  = {1'b0, fill_level}
                    + (hold_mode ? (FILL_W+1)'(1) : (FILL_W+1)'(CHUNK_W));
        fill_next = (fill_sum >= {1'b0, FILL_MAX}) ? FILL_MAX : fill_sum[FILL_W-1:0];
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            window     <= '0;
            hold       <= '0;
            hold_cnt   <= '0;
            hold_mode  <= 1'b0;
            fill_level <= FILL_INIT;
            out_valid  <= 1'b0;
        end else if (flush) begin
            window     <= '0;
            hold       <= '0;
            hold_cnt   <= '0;
            hold_mode  <= 1'b0;
            fill_level <= FILL_INIT;
            out_valid  <= 1'b0;
        end else begin
            if (can_shift) begin
                if (hold_mode) begin
                    window   <= {window[OUT_W-2:0], hold[CHUNK_W-1]};
                    hold     <= {hold[CHUNK_W-2:0], 1'b0};
                    hold_cnt <= hold_cnt - CNT_ONE;
                end else begin
                    window   <= {window[HALO_W-1:0], hold};
                    hold_cnt <= '0;
                end
                fill_level <= fill_next;
                out_valid  <= (fill_next == FILL_MAX);
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
            // Accept only happens when the hold is empty or being drained
            // this cycle, so the load safely overrides the shift updates.
            if (accept) begin
                hold      <= din;
                hold_cnt  <= CNT_FULL;
                hold_mode <= step_bit;
            end
        end
    end

endmodule
